// File: rtl/stopwatch_control.sv
// stopwatch_control: stop/run/pause/adjust sequencer for the MM:SS stopwatch.
// Keeps the BCD count and registers per-field blanking for the display mux.
module stopwatch_control #(
    parameter int MIN_MAX = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_clk,
    input  logic       blink_clk,
    input  logic       pause_p,
    input  logic       clear_p,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [1:0] state,
    output logic       blank_min,
    output logic       blank_sec,
    output logic       rollover
);

    typedef enum logic [1:0] {
        S_STOP  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_ADJ   = 2'b11
    } state_t;

    localparam logic [3:0] MAX_T = 4'(MIN_MAX / 10);
    localparam logic [3:0] MAX_O = 4'(MIN_MAX % 10);

    state_t     st_q, st_d;
    logic       sec_q, blink_q;
    logic       sec_edge, blink_edge;
    logic       sec_wrap, min_wrap;
    logic [3:0] mt_d, mo_d, stn_d, so_d;
    logic [3:0] mt_inc, mo_inc, stn_inc, so_inc;
    logic       roll_d, bmin_d, bsec_d;

    assign sec_edge   = sec_clk & ~sec_q;
    assign blink_edge = blink_clk & ~blink_q;
    assign state      = st_q;

    assign sec_wrap = (sec_tens == 4'd5) && (sec_ones == 4'd9);
    assign min_wrap = (min_tens == MAX_T) && (min_ones == MAX_O);

    // Field increments; each wraps on its own, carry is applied below.
    always_comb begin
        so_inc  = (sec_ones == 4'd9) ? 4'd0 : sec_ones + 4'd1;
        stn_inc = sec_tens;
        if (sec_ones == 4'd9)
            stn_inc = (sec_tens == 4'd5) ? 4'd0 : sec_tens + 4'd1;
        mo_inc = (min_ones == 4'd9) ? 4'd0 : min_ones + 4'd1;
        mt_inc = (min_ones == 4'd9) ? min_tens + 4'd1 : min_tens;
        if (min_wrap) begin
            mo_inc = 4'd0;
            mt_inc = 4'd0;
        end
    end

    always_comb begin
        st_d   = st_q;
        mt_d   = min_tens;
        mo_d   = min_ones;
        stn_d  = sec_tens;
        so_d   = sec_ones;
        roll_d = 1'b0;
        if (clear_p) begin
            mt_d  = 4'd0;
            mo_d  = 4'd0;
            stn_d = 4'd0;
            so_d  = 4'd0;
            st_d  = (st_q == S_ADJ) ? S_ADJ : S_STOP;
        end else begin
            if (st_q == S_RUN && sec_edge) begin
                so_d  = so_inc;
                stn_d = stn_inc;
                if (sec_wrap) begin
                    mo_d   = mo_inc;
                    mt_d   = mt_inc;
                    roll_d = min_wrap;
                end
            end
            if (st_q == S_ADJ && blink_edge) begin
                if (sel) begin
                    mo_d = mo_inc;
                    mt_d = mt_inc;
                end else begin
                    so_d  = so_inc;
                    stn_d = stn_inc;
                end
            end
            unique case (st_q)
                S_STOP: begin
                    if (adj)
                        st_d = S_ADJ;
                    else if (pause_p)
                        st_d = S_RUN;
                end
                S_RUN: begin
                    if (adj)
                        st_d = S_ADJ;
                    else if (pause_p)
                        st_d = S_PAUSE;
                end
                S_PAUSE: begin
                    if (adj)
                        st_d = S_ADJ;
                    else if (pause_p)
                        st_d = S_RUN;
                end
                S_ADJ: begin
                    if (!adj)
                        st_d = S_PAUSE;
                end
                default: st_d = S_STOP;
            endcase
        end
        // Keyed off the next state so blanking never lingers past ADJUST.
        bsec_d = (st_d == S_ADJ) & ~sel & blink_clk;
        bmin_d = (st_d == S_ADJ) & sel & blink_clk;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q      <= S_STOP;
            sec_q     <= sec_clk;
            blink_q   <= blink_clk;
            min_tens  <= 4'd0;
            min_ones  <= 4'd0;
            sec_tens  <= 4'd0;
            sec_ones  <= 4'd0;
            blank_min <= 1'b0;
            blank_sec <= 1'b0;
            rollover  <= 1'b0;
        end else begin
            st_q      <= st_d;
            sec_q     <= sec_clk;
            blink_q   <= blink_clk;
            min_tens  <= mt_d;
            min_ones  <= mo_d;
            sec_tens  <= stn_d;
            sec_ones  <= so_d;
            blank_min <= bmin_d;
            blank_sec <= bsec_d;
            rollover  <= roll_d;
        end
    end

endmodule

// File: tb/tb_stopwatch_control.sv
// tb_stopwatch_control: directed plus random stimulus against a
// seconds-count reference model of the stopwatch.
module tb_stopwatch_control;

    localparam int MIN_MAX = 59;

    logic       clk = 1'b0;
    logic       rst, sec_clk, blink_clk;
    logic       pause_p, clear_p, adj, sel;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic [1:0] state;
    logic       blank_min, blank_sec, rollover;

    stopwatch_control #(.MIN_MAX(MIN_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .sec_clk   (sec_clk),
        .blink_clk (blink_clk),
        .pause_p   (pause_p),
        .clear_p   (clear_p),
        .adj       (adj),
        .sel       (sel),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .state     (state),
        .blank_min (blank_min),
        .blank_sec (blank_sec),
        .rollover  (rollover)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int sdiv = 0;
    int bdiv = 0;

    // Model: state 0..3 as STOP/RUN/PAUSE/ADJUST, count as minutes+seconds.
    int m_st, m_min, m_sec;
    bit m_bs, m_bm, m_roll, m_sq, m_bq;

    task automatic chk(input string n, input int got, input int exp);
        checks++;
        if (got == exp)
            passed++;
        else
            $display("FAIL %s: got %0d expected %0d at %0t",
                     n, got, exp, $time);
    endtask

    task automatic model_step();
        bit se, be;
        int t;
        se = sec_clk && !m_sq;
        be = blink_clk && !m_bq;
        m_sq = sec_clk;
        m_bq = blink_clk;
        if (rst) begin
            m_st = 0; m_min = 0; m_sec = 0;
            m_bs = 0; m_bm = 0; m_roll = 0;
            return;
        end
        m_roll = 0;
        if (clear_p) begin
            m_min = 0;
            m_sec = 0;
            if (m_st != 3) m_st = 0;
        end else begin
            if (m_st == 1 && se) begin
                t = m_min * 60 + m_sec + 1;
                if (t == (MIN_MAX + 1) * 60) begin
                    t = 0;
                    m_roll = 1;
                end
                m_min = t / 60;
                m_sec = t % 60;
            end
            if (m_st == 3 && be) begin
                if (sel) m_min = (m_min == MIN_MAX) ? 0 : m_min + 1;
                else     m_sec = (m_sec + 1) % 60;
            end
            if (m_st == 3) begin
                if (!adj) m_st = 2;
            end else if (adj) begin
                m_st = 3;
            end else if (pause_p) begin
                m_st = (m_st == 1) ? 2 : 1;
            end
        end
        m_bs = (m_st == 3) && !sel && blink_clk;
        m_bm = (m_st == 3) && sel && blink_clk;
    endtask

    // One clock: model update, per-cycle compare, then next divider levels.
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("state", int'(state), m_st);
        chk("min_tens", int'(min_tens), m_min / 10);
        chk("min_ones", int'(min_ones), m_min % 10);
        chk("sec_tens", int'(sec_tens), m_sec / 10);
        chk("sec_ones", int'(sec_ones), m_sec % 10);
        chk("blank_min", int'(blank_min), int'(m_bm));
        chk("blank_sec", int'(blank_sec), int'(m_bs));
        chk("rollover", int'(rollover), int'(m_roll));
        pause_p = 1'b0;
        clear_p = 1'b0;
        rst     = 1'b0;
        sdiv = (sdiv + 1) % 8;
        sec_clk = (sdiv >= 4);
        bdiv = (bdiv + 1) % 6;
        blink_clk = (bdiv >= 3);
    endtask

    task automatic wait_rises(input int n);
        int r = 0;
        while (r < n) begin
            bit p = sec_clk;
            cyc();
            if (sec_clk && !p) r++;
        end
    endtask

    task automatic wait_brises(input int n);
        int r = 0;
        while (r < n) begin
            bit p = blink_clk;
            cyc();
            if (blink_clk && !p) r++;
        end
    endtask

    task automatic lit_count(input string n, input int mm, input int ss);
        chk({n, "_min"}, int'(min_tens) * 10 + int'(min_ones), mm);
        chk({n, "_sec"}, int'(sec_tens) * 10 + int'(sec_ones), ss);
    endtask

    // Enter adjust, clear, dial in mm:ss, then drop back to PAUSE.
    task automatic preload(input int mm, input int ss);
        adj = 1'b1;
        cyc();
        while (bdiv != 0) cyc();
        clear_p = 1'b1;
        cyc();
        sel = 1'b1;
        wait_brises(mm);
        cyc();
        sel = 1'b0;
        wait_brises(ss);
        cyc();
        adj = 1'b0;
        cyc();
    endtask

    task automatic to_run();
        while (sdiv != 0) cyc();
        pause_p = 1'b1;
        cyc();
    endtask

    initial begin
        rst = 1'b1; sec_clk = 1'b0; blink_clk = 1'b0;
        pause_p = 1'b0; clear_p = 1'b0; adj = 1'b0; sel = 1'b0;
        m_st = 0; m_min = 0; m_sec = 0;
        m_bs = 0; m_bm = 0; m_roll = 0; m_sq = 0; m_bq = 0;

        rst = 1'b1;
        cyc();
        rst = 1'b1;
        cyc();
        chk("lit_reset_state", int'(state), 0);
        lit_count("lit_reset", 0, 0);

        // Basic count
        to_run();
        wait_rises(12);
        cyc();
        chk("lit_basic_state", int'(state), 1);
        lit_count("lit_basic", 0, 12);
        chk("lit_basic_roll", int'(rollover), 0);

        // Wrap from 59:58
        preload(59, 58);
        lit_count("lit_preload", 59, 58);
        chk("lit_preload_state", int'(state), 2);
        to_run();
        wait_rises(1);
        cyc();
        lit_count("lit_wrap1", 59, 59);
        wait_rises(1);
        cyc();
        lit_count("lit_wrap2", 0, 0);
        chk("lit_wrap_roll", int'(rollover), 1);
        cyc();
        chk("lit_wrap_roll_off", int'(rollover), 0);

        // Pause / resume
        wait_rises(5);
        cyc();
        lit_count("lit_run5", 0, 5);
        pause_p = 1'b1;
        cyc();
        chk("lit_pause_state", int'(state), 2);
        wait_rises(3);
        cyc();
        lit_count("lit_paused", 0, 5);
        to_run();
        chk("lit_resume_state", int'(state), 1);
        wait_rises(1);
        cyc();
        lit_count("lit_resumed", 0, 6);

        // Adjust seconds from 00:57
        wait_rises(51);
        cyc();
        lit_count("lit_at57", 0, 57);
        pause_p = 1'b1;
        cyc();
        while (bdiv != 0) cyc();
        adj = 1'b1;
        sel = 1'b0;
        cyc();
        chk("lit_adj_state", int'(state), 3);
        wait_brises(4);
        cyc();
        lit_count("lit_adj_sec", 0, 1);
        chk("lit_adj_bsec", int'(blank_sec), 1);
        chk("lit_adj_bmin", int'(blank_min), 0);
        adj = 1'b0;
        cyc();
        chk("lit_adj_exit", int'(state), 2);
        chk("lit_adj_exit_bsec", int'(blank_sec), 0);

        // Priority: clear + pause + sec_edge in RUN at 03:14
        preload(3, 14);
        to_run();
        lit_count("lit_pri_pre", 3, 14);
        wait_rises(1);
        clear_p = 1'b1;
        pause_p = 1'b1;
        cyc();
        chk("lit_pri_state", int'(state), 0);
        lit_count("lit_pri", 0, 0);
        chk("lit_pri_roll", int'(rollover), 0);
        pause_p = 1'b1;
        cyc();
        pause_p = 1'b1;
        cyc();
        adj = 1'b1;
        pause_p = 1'b1;
        cyc();
        chk("lit_adj_over_pause", int'(state), 3);
        adj = 1'b0;
        cyc();

        // Reset in RUN at 10:20 with sec_clk high at release
        preload(10, 20);
        to_run();
        lit_count("lit_rst_pre", 10, 20);
        wait_rises(1);
        rst = 1'b1;
        cyc();
        chk("lit_rst_state", int'(state), 0);
        lit_count("lit_rst", 0, 0);
        pause_p = 1'b1;
        cyc();
        cyc();
        lit_count("lit_rst_noinc", 0, 0);
        wait_rises(1);
        cyc();
        lit_count("lit_rst_inc", 0, 1);

        // Random phase
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(39) == 0) adj = ~adj;
            if ($urandom_range(9) == 0) sel = ~sel;
            pause_p = ($urandom_range(11) == 0);
            clear_p = ($urandom_range(99) == 0);
            rst = ($urandom_range(299) == 0);
            cyc();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
